data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Responder end of the pipeline's data-memory bus: accepts the address, write data and write mode that the MEM stage drives, and returns read data.
- Word-organised synchronous RAM with a configurable fixed read latency, a valid/ready request handshake, a read-return pipeline and misalignment detection.
- Sits beside the CPU core. The MEM stage is the initiator; this block is the memory it talks to.

Parameters:
- ADDR_W, 12, byte-address width on the bus.
- DATA_W, 16, word width.
- DEPTH_WORDS, 2048, number of words stored (2**(ADDR_W-1)).
- READ_LATENCY, 1, cycles from accepted read to rdata_valid; legal range 1..4.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  request valid from the MEM stage.
- ready  out  1  responder can accept a request this cycle.
- addr  in  ADDR_W  byte address; word index is addr[ADDR_W-1:1].
- wdata  in  DATA_W  write data.
- write_mode  in  1  1 = write, 0 = read.
- rdata  out  DATA_W  read data.
- rdata_valid  out  1  rdata holds the result of a read; one-cycle pulse per read.
- misalign_err  out  1  one-cycle pulse: the accepted request had addr[0]=1.

Behaviour:
- Reset (async assert) sets ready=0, rdata=0, rdata_valid=0, misalign_err=0, flushes the read pipeline and sets state=INIT (feature on) or IDLE (feature off). Reset does not clear RAM contents by itself.
- Reset asserted mid-operation drops all in-flight reads; they produce no rdata_valid pulse.
- Acceptance condition: req && ready at posedge.
- FSM states: INIT, IDLE.
  - INIT: ready=0; a clear counter walks the words. INIT exits to IDLE when the counter reaches DEPTH_WORDS-1.
  - IDLE: ready=1; stays in IDLE until reset.
- Accepted write with addr[0]=0:
  - RAM[word] <= wdata at that posedge.
  - No rdata_valid.
- Accepted read with addr[0]=0:
  - RAM[word] is sampled at acceptance and enters a READ_LATENCY-deep shift pipeline.
  - rdata/rdata_valid appear exactly READ_LATENCY cycles after acceptance.
- Back-to-back reads, one per cycle, are fully pipelined. No request is ever stalled in IDLE.
- Write then read of the same word in consecutive cycles: the read returns the new data (the write commits at the earlier edge).
- Misaligned request (addr[0]=1):
  - Write is dropped.
  - Read returns rdata=0 with rdata_valid=1 after READ_LATENCY.
  - misalign_err pulses in the cycle after acceptance, for both reads and writes.
- rdata holds its last value when rdata_valid=0.
- Idle cycles (req=0) insert bubbles in the pipeline.
- Address wrap: word index uses only addr[ADDR_W-1:1]; no out-of-range condition exists.
- req while ready=0 is ignored, with no side effects; the initiator must hold the request until ready=1.

Optional Feature:
- Macro: DMEM_ZERO_INIT_EN.
- Defined: after reset release, the FSM sits in INIT for DEPTH_WORDS cycles writing 0 to every word. ready first rises on the cycle after the last clear write. Reads in any later cycle return 0 for unwritten words.
- Undefined: there is no INIT state and no clear counter; ready=1 from the first posedge after reset release. RAM powers up with undefined contents (X in simulation).

Decomposition:
- Shared package dmem_pkg:
  - typedef state_t {INIT, IDLE}.
  - localparams WORD_IDX_W = ADDR_W-1 and MAX_READ_LATENCY = 4.
  - typedef rd_slot_t {valid, misaligned, data}.
- One sub-module: dmem_read_pipe, a parameterised READ_LATENCY-deep shift register of rd_slot_t with async active-low flush.
- RAM array, FSM and acceptance logic stay in the top module.

Test Plan:
1. DMEM_ZERO_INIT_EN defined, reset released -> ready stays 0 for 2048 cycles, then rises. A read of addr 0x0400 then returns rdata=0x0000 after READ_LATENCY cycles.
2. Write 0xBEEF to 0x0010 (req held until ready), then read 0x0010 on the next cycle -> rdata=0xBEEF with a single rdata_valid pulse exactly READ_LATENCY cycles after read acceptance. Repeat with READ_LATENCY=1 and 3.
3. Reads of 0x0002, 0x0004 and 0x0006 on consecutive cycles, after writing 0x1111, 0x2222 and 0x3333 -> three consecutive rdata_valid pulses, returned in request order.
4. Write 0xFFFD to misaligned 0x0011 -> misalign_err pulse the next cycle; a read of 0x0010 still returns its prior value. A read of 0x0011 -> rdata=0, rdata_valid=1, misalign_err=1.
5. Assert rst_n=0 while two reads are in flight (READ_LATENCY=3) -> no rdata_valid afterwards, outputs zero immediately (asynchronously). Data written before the reset persists when DMEM_ZERO_INIT_EN is undefined.
6. Hold req=1 during INIT with write_mode=1 -> no RAM change; after INIT a read of the same address returns 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and sizing for the data-memory responder.
// Bus widths are fixed here so the interface, pipeline and top agree.
package dmem_pkg;

    localparam int ADDR_W           = 12;
    localparam int DATA_W           = 16;
    localparam int WORD_IDX_W       = ADDR_W - 1;
    localparam int DEPTH_WORDS      = 2 ** WORD_IDX_W;
    localparam int MAX_READ_LATENCY = 4;

    typedef enum logic {
        INIT,
        IDLE
    } state_t;

    typedef struct packed {
        logic              valid;
        logic              misaligned;
        logic [DATA_W-1:0] data;
    } rd_slot_t;

    // Byte address to word index; the LSB only flags misalignment.
    function automatic logic [WORD_IDX_W-1:0] word_index(input logic [ADDR_W-1:0] byte_addr);
        return byte_addr[ADDR_W-1:1];
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Data-memory bus between the MEM stage (master) and the responder (slave).
interface data_mem_responder_if;

    logic                          req;
    logic                          ready;
    logic [dmem_pkg::ADDR_W-1:0]   addr;
    logic [dmem_pkg::DATA_W-1:0]   wdata;
    logic                          write_mode;
    logic [dmem_pkg::DATA_W-1:0]   rdata;
    logic                          rdata_valid;
    logic                          misalign_err;

    modport master (
        output req, addr, wdata, write_mode,
        input  ready, rdata, rdata_valid, misalign_err
    );

    modport slave (
        input  req, addr, wdata, write_mode,
        output ready, rdata, rdata_valid, misalign_err
    );

endinterface

// File: rtl/data_mem_responder_read_pipe.sv
// Read-return shift pipeline: READ_LATENCY slots, async active-low flush.
// Slot payloads only move with a valid entry so the last slot holds its data across bubbles.
module dmem_read_pipe
    import dmem_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    input  rd_slot_t in_slot,
    output rd_slot_t out_slot
);

    if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_latency
        $error("dmem_read_pipe: READ_LATENCY must be 1..%0d", MAX_READ_LATENCY);
    end

    rd_slot_t stage [READ_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                stage[i] <= '0;
            end
        end else begin
            if (in_slot.valid) begin
                stage[0] <= in_slot;
            end else begin
                stage[0].valid <= 1'b0;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                if (stage[i-1].valid) begin
                    stage[i] <= stage[i-1];
                end else begin
                    stage[i].valid <= 1'b0;
                end
            end
        end
    end

    assign out_slot = stage[READ_LATENCY-1];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM, request acceptance, misalignment flag, read-return pipeline.
// Optional DMEM_ZERO_INIT_EN: clears every word in an INIT state after reset before accepting requests.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus
);

    logic [DATA_W-1:0]     mem [DEPTH_WORDS];
    logic                  ready_q;
    logic                  misalign_q;
    logic                  accept;
    logic                  misaligned;
    logic [WORD_IDX_W-1:0] word;
    logic                  clr_we;
    logic [WORD_IDX_W-1:0] clr_addr;
    rd_slot_t              in_slot;
    rd_slot_t              out_slot;

    assign accept     = bus.req && ready_q;
    assign misaligned = bus.addr[0];
    assign word       = word_index(bus.addr);

`ifdef DMEM_ZERO_INIT_EN
    state_t                state;
    logic [WORD_IDX_W-1:0] clr_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= INIT;
            clr_cnt <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == WORD_IDX_W'(DEPTH_WORDS - 1)) begin
                        state   <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Clearing is held off while reset is asserted so reset alone never touches the RAM.
    assign clr_we   = (state == INIT) && rst_n;
    assign clr_addr = clr_cnt;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (accept && bus.write_mode && !misaligned) begin
            mem[word] <= bus.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= accept && misaligned;
        end
    end

    // A read samples the RAM at acceptance; a write in the previous cycle is already committed.
    always_comb begin
        in_slot            = '0;
        in_slot.valid      = accept && !bus.write_mode;
        in_slot.misaligned = misaligned;
        in_slot.data       = mem[word];
    end

    dmem_read_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_read_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_slot  (in_slot),
        .out_slot (out_slot)
    );

    assign bus.ready        = ready_q;
    assign bus.rdata        = out_slot.misaligned ? '0 : out_slot.data;
    assign bus.rdata_valid  = out_slot.valid;
    assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (READ_LATENCY 1 and 3) on identical stimulus,
// checked against a word-array and response-queue model; honours DMEM_ZERO_INIT_EN.
module tb_data_mem_responder;
    import dmem_pkg::*;

`ifdef DMEM_ZERO_INIT_EN
    localparam int READY_EDGES = DEPTH_WORDS;
`else
    localparam int READY_EDGES = 1;
`endif

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic              req   = 1'b0;
    logic              write_mode = 1'b0;
    logic [ADDR_W-1:0] addr  = '0;
    logic [DATA_W-1:0] wdata = '0;

    always #5 clk = ~clk;

    data_mem_responder_if bus1 ();
    data_mem_responder_if bus3 ();

    assign bus1.req = req;  assign bus1.addr = addr;  assign bus1.wdata = wdata;  assign bus1.write_mode = write_mode;
    assign bus3.req = req;  assign bus3.addr = addr;  assign bus3.wdata = wdata;  assign bus3.write_mode = write_mode;

    data_mem_responder #(.READ_LATENCY(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    data_mem_responder #(.READ_LATENCY(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3.slave));

    logic              o_valid [2];
    logic              o_mis   [2];
    logic              o_ready [2];
    logic [DATA_W-1:0] o_rdata [2];
    assign o_valid[0] = bus1.rdata_valid;  assign o_valid[1] = bus3.rdata_valid;
    assign o_mis[0]   = bus1.misalign_err; assign o_mis[1]   = bus3.misalign_err;
    assign o_ready[0] = bus1.ready;        assign o_ready[1] = bus3.ready;
    assign o_rdata[0] = bus1.rdata;        assign o_rdata[1] = bus3.rdata;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
        bit                known;
    } rsp_t;

    rsp_t              exp_q [2][$];
    int                lat [2] = '{1, 3};
    logic [DATA_W-1:0] mem_m   [DEPTH_WORDS];
    bit                known_m [DEPTH_WORDS];
    logic [DATA_W-1:0] last_rd    [2];
    bit                last_known [2];
    int                edges;
    bit                ready_m;
    bit                last_acc;
    int                cyc;
    int                n_checks = 0;
    int                n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        else             n_pass++;
    endtask

    task automatic check_outputs(input bit exp_mis);
        for (int d = 0; d < 2; d++) begin
            bit   ev;
            rsp_t r;
            ev = (exp_q[d].size() > 0) && (exp_q[d][0].due == cyc);
            check_eq($sformatf("rdata_valid[L%0d]", lat[d]), 32'(o_valid[d]), 32'(ev));
            if (ev) begin
                r = exp_q[d].pop_front();
                last_rd[d]    = r.data;
                last_known[d] = r.known;
            end
            if (last_known[d]) check_eq($sformatf("rdata[L%0d]", lat[d]), 32'(o_rdata[d]), 32'(last_rd[d]));
            check_eq($sformatf("misalign_err[L%0d]", lat[d]), 32'(o_mis[d]), 32'(exp_mis));
            check_eq($sformatf("ready[L%0d]", lat[d]), 32'(o_ready[d]), 32'(ready_m));
        end
    endtask

    // One clock: model the request presented now, advance past the edge, then compare.
    task automatic step();
        bit                acc;
        bit                mis;
        int                w;
        logic [DATA_W-1:0] rd;
        bit                rk;
        acc = req && ready_m && rst_n;
        mis = addr[0];
        w   = int'(addr[ADDR_W-1:1]);
        @(posedge clk);
        cyc++;
        if (acc && write_mode && !mis) begin
            mem_m[w]   = wdata;
            known_m[w] = 1'b1;
        end else if (acc && !write_mode) begin
            rd = mis ? '0 : mem_m[w];
            rk = mis ? 1'b1 : known_m[w];
            for (int d = 0; d < 2; d++) exp_q[d].push_back('{due: cyc + lat[d] - 1, data: rd, known: rk});
        end
        if (rst_n) edges++;
`ifdef DMEM_ZERO_INIT_EN
        if (rst_n && edges == DEPTH_WORDS) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_m[i]   = '0;
                known_m[i] = 1'b1;
            end
        end
`endif
        ready_m = rst_n && (edges >= READY_EDGES);
        #1;
        check_outputs(acc && mis);
        last_acc = acc;
    endtask

    task automatic apply_reset(input int cycles);
        rst_n = 1'b0;
        req   = 1'b0;
        edges = 0;
        ready_m = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_q[d].delete();
            last_rd[d]    = '0;
            last_known[d] = 1'b1;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("rst_rdata[L%0d]", lat[d]), 32'(o_rdata[d]), 32'h0);
            check_eq($sformatf("rst_valid[L%0d]", lat[d]), 32'(o_valid[d]), 32'h0);
            check_eq($sformatf("rst_mis[L%0d]", lat[d]), 32'(o_mis[d]), 32'h0);
            check_eq($sformatf("rst_ready[L%0d]", lat[d]), 32'(o_ready[d]), 32'h0);
        end
        repeat (cycles) step();
        rst_n = 1'b1;
    endtask

    task automatic do_req(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        req = 1'b1; write_mode = wr; addr = a; wdata = d;
        do begin
            step();
            n++;
        end while (!last_acc && n < 5000);
        req = 1'b0;
        if (!last_acc) check_eq("req_accept_timeout", 32'h0, 32'h1);
    endtask

    task automatic idle(input int n);
        req = 1'b0;
        repeat (n) step();
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready_m && n < 5000) begin
            step();
            n++;
        end
        if (!ready_m) check_eq("ready_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        int idx;
        cyc = 0;
        for (int i = 0; i < DEPTH_WORDS; i++) known_m[i] = 1'b0;
        apply_reset(3);

`ifdef DMEM_ZERO_INIT_EN
        wait_ready();
        check_eq("init_cycles", 32'(edges), 32'(DEPTH_WORDS));
        do_req(1'b0, 12'h400, '0);
        idle(4);
`else
        idle(2);
`endif

        // Write then read of the same word back to back
        do_req(1'b1, 12'h010, 16'hBEEF);
        do_req(1'b0, 12'h010, '0);
        idle(4);

        // Three pipelined reads return in order
        do_req(1'b1, 12'h002, 16'h1111);
        do_req(1'b1, 12'h004, 16'h2222);
        do_req(1'b1, 12'h006, 16'h3333);
        do_req(1'b0, 12'h002, '0);
        do_req(1'b0, 12'h004, '0);
        do_req(1'b0, 12'h006, '0);
        idle(5);

        // Misaligned write dropped, misaligned read returns zero
        do_req(1'b1, 12'h011, 16'hFFFD);
        do_req(1'b0, 12'h010, '0);
        do_req(1'b0, 12'h011, '0);
        idle(5);

        // Reset with reads in flight drops them; RAM contents survive
        do_req(1'b0, 12'h002, '0);
        do_req(1'b0, 12'h004, '0);
        apply_reset(2);
        wait_ready();
        do_req(1'b0, 12'h002, '0);
        do_req(1'b0, 12'h010, '0);
        idle(5);

`ifdef DMEM_ZERO_INIT_EN
        // Requests during INIT are ignored
        apply_reset(2);
        req = 1'b1; write_mode = 1'b1; addr = 12'h100; wdata = 16'hABCD;
        wait_ready();
        req = 1'b0;
        do_req(1'b0, 12'h100, '0);
        idle(4);
`endif

        // Random traffic over a small pool of words at both ends of the array
        for (int k = 0; k < 16; k++) begin
            idx = (k < 8) ? k : DEPTH_WORDS - 16 + k;
            do_req(1'b1, ADDR_W'(idx << 1), DATA_W'($urandom));
        end
        for (int n = 0; n < 400; n++) begin
            int k;
            k = $urandom_range(0, 15);
            idx = (k < 8) ? k : DEPTH_WORDS - 16 + k;
            req        = ($urandom_range(0, 3) != 0);
            write_mode = $urandom_range(0, 1) == 1;
            addr       = ADDR_W'((idx << 1) | (($urandom_range(0, 7) == 0) ? 1 : 0));
            wdata      = DATA_W'($urandom);
            step();
        end
        idle(6);
        for (int d = 0; d < 2; d++) check_eq($sformatf("drained[L%0d]", lat[d]), 32'(exp_q[d].size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
